// File: rtl/pid_cfg_pkg.sv
// rtl/pid_cfg_pkg.sv - shared types and constants for the PID coefficient loader
package pid_cfg_pkg;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] SEL_D    = 8'h01;
   localparam logic [7:0] SEL_Q    = 8'h02;
   localparam logic [7:0] SEL_DQ   = 8'h03;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_SEL   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CSUM  = 3'd4,
      ST_WRITE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_SEL     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   // Number of payload bytes needed to carry a coefficient of the given width
   function automatic int data_bytes(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/cfg_idle_timer.sv
// rtl/cfg_idle_timer.sv - idle-cycle counter that flags expiry after LIMIT idle cycles
module cfg_idle_timer #(
   parameter int LIMIT = 1024
)(
   input  logic clk,
   input  logic rstb,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_expire;

   // A clear in the expiry cycle suppresses expiry, so an arriving byte wins
   assign w_expire = i_en && !i_clr && (r_cnt == LAST);
   assign o_expire = w_expire;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_cnt <= '0;
      end else if (i_clr || w_expire) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pid_coef_loader.sv
// rtl/pid_coef_loader.sv - parses framed host bytes into PID coefficient register writes
module pid_coef_loader
   import pid_cfg_pkg::*;
#(
   parameter int D_WIDTH  = 19,
   parameter int NUM_COEF = 3,
   parameter int TIMEOUT  = 1024
)(
   input  logic               clk,
   input  logic               rstb,
   input  logic               i_in_valid,
   input  logic [7:0]         i_in_data,
   output logic               o_in_ready,
   output logic               o_pid_d_wen,
   output logic               o_pid_q_wen,
   output logic [D_WIDTH-1:0] o_pid_d_addr,
   output logic [D_WIDTH-1:0] o_pid_q_addr,
   output logic [D_WIDTH-1:0] o_pid_d_data,
   output logic [D_WIDTH-1:0] o_pid_q_data,
   output logic               o_frame_ok,
   output logic               o_frame_err,
   output logic [1:0]         o_err_code,
   output logic [7:0]         o_err_cnt
);

   localparam int DB  = data_bytes(D_WIDTH);
   localparam int BCW = (DB > 2) ? $clog2(DB) : 1;
   localparam logic [BCW-1:0] BCNT_LAST = BCW'(DB - 1);

   state_t             r_state;
   state_t             w_next;
   logic [7:0]         r_sel;
   logic [7:0]         r_addr;
   logic [7:0]         r_csum;
   logic [D_WIDTH-1:0] r_data;
   logic [BCW-1:0]     r_bcnt;

   logic               r_d_wen;
   logic               r_q_wen;
   logic [D_WIDTH-1:0] r_d_addr;
   logic [D_WIDTH-1:0] r_q_addr;
   logic [D_WIDTH-1:0] r_d_data;
   logic [D_WIDTH-1:0] r_q_data;
   logic               r_frame_ok;
   logic               r_frame_err;
   err_code_t          r_err_code;
   logic [7:0]         r_err_cnt;

   logic               w_ready;
   logic               w_accept;
   logic               w_in_frame;
   logic               w_expire;
   logic               w_sel_ok;
   logic               w_addr_ok;
   logic               w_commit;
   logic               w_reject;
   err_code_t          w_rej_code;

   // Ready is gated by reset directly so it reads 0 for the whole reset assertion
   assign w_ready    = !rstb && (r_state != ST_WRITE);
   assign w_accept   = i_in_valid && w_ready;
   assign w_in_frame = (r_state == ST_SEL) || (r_state == ST_ADDR) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);
   assign w_sel_ok   = (r_sel == SEL_D) || (r_sel == SEL_Q) || (r_sel == SEL_DQ);
   assign w_addr_ok  = (32'(r_addr) < NUM_COEF);

   cfg_idle_timer #(
      .LIMIT    (TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .rstb     (rstb),
      .i_clr    (w_accept || !w_in_frame),
      .i_en     (w_in_frame),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_state <= ST_HUNT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_commit   = 1'b0;
      w_reject   = 1'b0;
      w_rej_code = ERR_NONE;
      case (r_state)
         ST_HUNT: begin
            if (w_accept && (i_in_data == HDR_BYTE)) w_next = ST_SEL;
         end
         ST_SEL: begin
            if (w_accept) w_next = ST_ADDR;
         end
         ST_ADDR: begin
            if (w_accept) w_next = ST_DATA;
         end
         ST_DATA: begin
            if (w_accept && (r_bcnt == BCNT_LAST)) w_next = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_accept) begin
               if (i_in_data != r_csum) begin
                  w_reject   = 1'b1;
                  w_rej_code = ERR_CSUM;
                  w_next     = ST_HUNT;
               end else if (!w_sel_ok || !w_addr_ok) begin
                  w_reject   = 1'b1;
                  w_rej_code = ERR_SEL;
                  w_next     = ST_HUNT;
               end else begin
                  w_commit   = 1'b1;
                  w_next     = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            w_next = ST_HUNT;
         end
         default: begin
            w_next = ST_HUNT;
         end
      endcase
      if (w_expire) begin
         w_reject   = 1'b1;
         w_rej_code = ERR_TIMEOUT;
         w_next     = ST_HUNT;
      end
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_sel  <= '0;
         r_addr <= '0;
         r_csum <= '0;
         r_data <= '0;
         r_bcnt <= '0;
      end else if (w_accept) begin
         case (r_state)
            ST_SEL: begin
               r_sel  <= i_in_data;
               r_csum <= i_in_data;
            end
            ST_ADDR: begin
               r_addr <= i_in_data;
               r_csum <= r_csum ^ i_in_data;
               r_bcnt <= '0;
            end
            ST_DATA: begin
               // Shifting through a D_WIDTH register drops any excess high bits
               r_data <= D_WIDTH'({r_data, i_in_data});
               r_csum <= r_csum ^ i_in_data;
               r_bcnt <= r_bcnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         r_d_wen     <= 1'b0;
         r_q_wen     <= 1'b0;
         r_d_addr    <= '0;
         r_q_addr    <= '0;
         r_d_data    <= '0;
         r_q_data    <= '0;
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_err_cnt   <= '0;
      end else begin
         r_d_wen     <= w_commit && r_sel[0];
         r_q_wen     <= w_commit && r_sel[1];
         r_frame_ok  <= w_commit;
         r_frame_err <= w_reject;
         if (w_commit && r_sel[0]) begin
            r_d_addr <= D_WIDTH'(r_addr);
            r_d_data <= r_data;
         end
         if (w_commit && r_sel[1]) begin
            r_q_addr <= D_WIDTH'(r_addr);
            r_q_data <= r_data;
         end
         if (w_reject) begin
            r_err_code <= w_rej_code;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         end else if (w_commit) begin
            r_err_code <= ERR_NONE;
         end
      end
   end

   assign o_in_ready   = w_ready;
   assign o_pid_d_wen  = r_d_wen;
   assign o_pid_q_wen  = r_q_wen;
   assign o_pid_d_addr = r_d_addr;
   assign o_pid_q_addr = r_q_addr;
   assign o_pid_d_data = r_d_data;
   assign o_pid_q_data = r_q_data;
   assign o_frame_ok   = r_frame_ok;
   assign o_frame_err  = r_frame_err;
   assign o_err_code   = r_err_code;
   assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_pid_coef_loader.sv
// tb/tb_pid_coef_loader.sv - scoreboard bench for the PID coefficient loader
module tb_pid_coef_loader;

   localparam int DW  = 19;
   localparam int TMO = 1024;

   logic          clk = 1'b0;
   logic          rstb;
   logic          i_in_valid;
   logic [7:0]    i_in_data;
   logic          o_in_ready;
   logic          o_pid_d_wen;
   logic          o_pid_q_wen;
   logic [DW-1:0] o_pid_d_addr;
   logic [DW-1:0] o_pid_q_addr;
   logic [DW-1:0] o_pid_d_data;
   logic [DW-1:0] o_pid_q_data;
   logic          o_frame_ok;
   logic          o_frame_err;
   logic [1:0]    o_err_code;
   logic [7:0]    o_err_cnt;

   typedef struct {
      logic          is_err;
      logic          d;
      logic          q;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
      logic [1:0]    code;
      logic [7:0]    cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   model_cnt = 0;

   always #5 clk = ~clk;

   pid_coef_loader dut (
      .clk          (clk),
      .rstb         (rstb),
      .i_in_valid   (i_in_valid),
      .i_in_data    (i_in_data),
      .o_in_ready   (o_in_ready),
      .o_pid_d_wen  (o_pid_d_wen),
      .o_pid_q_wen  (o_pid_q_wen),
      .o_pid_d_addr (o_pid_d_addr),
      .o_pid_q_addr (o_pid_q_addr),
      .o_pid_d_data (o_pid_d_data),
      .o_pid_q_data (o_pid_q_data),
      .o_frame_ok   (o_frame_ok),
      .o_frame_err  (o_frame_err),
      .o_err_code   (o_err_code),
      .o_err_cnt    (o_err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic exp_write(input logic d, input logic q, input logic [7:0] a, input logic [DW-1:0] v);
      exp_t e;
      e.is_err = 1'b0; e.d = d; e.q = q;
      e.addr = DW'(a); e.data = v; e.code = 2'd0; e.cnt = 8'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic exp_error(input logic [1:0] code);
      exp_t e;
      if (model_cnt < 255) model_cnt++;
      e.is_err = 1'b1; e.d = 1'b0; e.q = 1'b0;
      e.addr = '0; e.data = '0; e.code = code; e.cnt = 8'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data  = b;
      while (!o_in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         total++;
         bad++;
         $display("FAIL ready_wait actual=timeout required=ready byte=%0h", b);
      end
      @(posedge clk);
      #1 i_in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] sel, input logic [7:0] addr,
                             input logic [23:0] data, input logic [7:0] cs);
      send_byte(8'hA5);
      send_byte(sel);
      send_byte(addr);
      send_byte(data[23:16]);
      send_byte(data[15:8]);
      send_byte(data[7:0]);
      send_byte(cs);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  32'(o_in_ready),   32'h0);
      check({tag, "_wen"},    32'({o_pid_d_wen, o_pid_q_wen}), 32'h0);
      check({tag, "_pulses"}, 32'({o_frame_ok, o_frame_err}),  32'h0);
      check({tag, "_d_addr"}, 32'(o_pid_d_addr), 32'h0);
      check({tag, "_q_addr"}, 32'(o_pid_q_addr), 32'h0);
      check({tag, "_d_data"}, 32'(o_pid_d_data), 32'h0);
      check({tag, "_q_data"}, 32'(o_pid_q_data), 32'h0);
      check({tag, "_code"},   32'(o_err_code),   32'h0);
      check({tag, "_cnt"},    32'(o_err_cnt),    32'h0);
   endtask

   // Monitor: every strobe or frame pulse must match the next queued expectation
   always @(negedge clk) begin
      if (!rstb && (o_pid_d_wen || o_pid_q_wen || o_frame_ok || o_frame_err)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=d%0b q%0b ok%0b err%0b required=none",
                     o_pid_d_wen, o_pid_q_wen, o_frame_ok, o_frame_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("mon_d_wen",     32'(o_pid_d_wen), 32'(e.d));
            check("mon_q_wen",     32'(o_pid_q_wen), 32'(e.q));
            check("mon_frame_ok",  32'(o_frame_ok),  32'(!e.is_err));
            check("mon_frame_err", 32'(o_frame_err), 32'(e.is_err));
            check("mon_err_cnt",   32'(o_err_cnt),   32'(e.cnt));
            if (e.is_err) begin
               check("mon_err_code", 32'(o_err_code), 32'(e.code));
            end else begin
               check("mon_ready_in_write", 32'(o_in_ready), 32'h0);
               if (e.d) begin
                  check("mon_d_addr", 32'(o_pid_d_addr), 32'(e.addr));
                  check("mon_d_data", 32'(o_pid_d_data), 32'(e.data));
               end
               if (e.q) begin
                  check("mon_q_addr", 32'(o_pid_q_addr), 32'(e.addr));
                  check("mon_q_data", 32'(o_pid_q_data), 32'(e.data));
               end
            end
         end
      end
   end

   initial begin
      rstb       = 1'b1;
      i_in_valid = 1'b0;
      i_in_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rstb = 1'b0;

      // D-only write
      exp_write(1'b1, 1'b0, 8'h00, 19'h01000);
      send_frame(8'h01, 8'h00, 24'h001000, 8'h11);

      // Leading junk, then write to both channels
      exp_write(1'b1, 1'b1, 8'h01, 19'h00200);
      send_byte(8'h3C);
      send_byte(8'h77);
      send_frame(8'h03, 8'h01, 24'h000200, 8'h00);

      // Bad checksum, then Q write with excess high data bits
      exp_error(2'd1);
      send_frame(8'h01, 8'h00, 24'h001000, 8'h12);
      exp_write(1'b0, 1'b1, 8'h02, 19'h7FFFF);
      send_frame(8'h02, 8'h02, 24'hFFFFFF, 8'hFF);

      // Address out of range, bad select, and checksum priority over select
      exp_error(2'd2);
      send_frame(8'h01, 8'h03, 24'h000001, 8'h03);
      exp_error(2'd2);
      send_frame(8'h04, 8'h00, 24'h000001, 8'h05);
      exp_error(2'd1);
      send_frame(8'h04, 8'h00, 24'h000001, 8'h00);

      // Timeout after TIMEOUT idle cycles, then a clean frame
      exp_error(2'd3);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      idle(TMO);
      exp_write(1'b0, 1'b1, 8'h00, 19'h12345);
      send_frame(8'h02, 8'h00, 24'h012345, 8'h65);

      // Byte arriving at the last legal idle cycle must not abort
      exp_write(1'b1, 1'b0, 8'h01, 19'h3ABCD);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h01);
      idle(TMO - 1);
      send_byte(8'h03);
      send_byte(8'hAB);
      send_byte(8'hCD);
      send_byte(8'h65);

      // Reset mid-frame discards the partial frame
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      idle(2);
      @(negedge clk);
      rstb = 1'b1;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      rstb = 1'b0;
      model_cnt = 0;
      send_byte(8'h10);
      send_byte(8'h00);
      send_byte(8'h11);
      idle(4);
      @(negedge clk);
      check("post_reset_cnt", 32'(o_err_cnt), 32'h0);

      // 256 rejected frames saturate the error counter
      for (int i = 0; i < 256; i++) begin
         exp_error(2'd1);
         send_frame(8'h01, 8'h00, 24'h000000, 8'hFF);
      end
      idle(10);
      @(negedge clk);
      check("err_cnt_saturated", 32'(o_err_cnt), 32'd255);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
